// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store sequencer: access sizes,
// read/write direction and the sequencer state.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam logic RW_LOAD  = 1'b0;
    localparam logic RW_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Zero/sign extension of right-justified memory read data to 32 bits.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] ext
);

    always_comb begin
        ext = data;
        case (size)
            SZ_BYTE: ext = sgn ? {{24{data[7]}}, data[7:0]} : {24'b0, data[7:0]};
            SZ_HALF: ext = sgn ? {{16{data[15]}}, data[15:0]} : {16'b0, data[15:0]};
            default: ext = data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: accepts a request, checks alignment, drives
// the memory for ACCESS_CYCLES cycles and returns an extended response.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [1:0]  req_size,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  mem_a,
    output logic [31:0] mem_di,
    input  logic [31:0] mem_do,
    output logic [1:0]  mem_size,
    output logic        mem_rw,
    output logic        mem_e,
    output state_t      fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; the initiator holds its payload stable until then.

    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          lat_rw;
    logic [1:0]    lat_size;
    logic [7:0]    lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_signed;
    logic          req_err;
    logic          last_cycle;
    logic [31:0]   ext_data;

    assign req_err = (req_size == SZ_BAD) ||
                     (req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00);

    assign last_cycle = (cnt == LAST);

    mem_access_unit_load_extend u_load_extend (
        .data (mem_do),
        .size (lat_size),
        .sgn  (lat_signed),
        .ext  (ext_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_rw     <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= 8'h00;
            lat_wdata  <= 32'h0;
            lat_signed <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_rw     <= req_rw;
                        lat_size   <= req_size;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_signed <= req_signed;
                        cnt        <= '0;
                        if (req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (last_cycle) begin
                        rsp_rdata <= (lat_rw == RW_STORE) ? 32'h0 : ext_data;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_rw     = 1'b0;
        mem_e      = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = req_err ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_rw = lat_rw;
                // The write strobe fires only in the final access cycle so a
                // store lands exactly once however long the access is.
                mem_e  = lat_rw & last_cycle;
                if (last_cycle)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_a     = lat_addr;
    assign mem_size  = lat_size;
    assign mem_di    = lat_wdata;
    assign fsm_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: big-endian memory model, scoreboard
// of expected responses, back-pressure and a reset-interrupted store.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT with default ACCESS_CYCLES ----------------
    logic        reset, req_valid, req_ready, req_rw, req_signed;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [7:0]  mem_a;
    logic [31:0] mem_di, mem_do;
    logic [1:0]  mem_size;
    logic        mem_rw, mem_e;
    state_t      fsm_state;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do), .mem_size(mem_size),
        .mem_rw(mem_rw), .mem_e(mem_e), .fsm_state(fsm_state)
    );

    // Big-endian byte memory
    logic [7:0] mem [256];
    logic [7:0] a1, a2, a3;
    assign a1 = mem_a + 8'd1;
    assign a2 = mem_a + 8'd2;
    assign a3 = mem_a + 8'd3;

    always_comb begin
        mem_do = 32'h0;
        case (mem_size)
            SZ_BYTE: mem_do = {24'h0, mem[mem_a]};
            SZ_HALF: mem_do = {16'h0, mem[mem_a], mem[a1]};
            SZ_WORD: mem_do = {mem[mem_a], mem[a1], mem[a2], mem[a3]};
            default: mem_do = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_e) begin
            case (mem_size)
                SZ_BYTE: mem[mem_a] <= mem_di[7:0];
                SZ_HALF: begin mem[mem_a] <= mem_di[15:8]; mem[a1] <= mem_di[7:0]; end
                default: begin
                    mem[mem_a] <= mem_di[31:24]; mem[a1] <= mem_di[23:16];
                    mem[a2]    <= mem_di[15:8];  mem[a3] <= mem_di[7:0];
                end
            endcase
        end
    end

    int          we_cnt = 0;
    logic [7:0]  wr_a;
    logic [1:0]  wr_size;
    logic [31:0] wr_di;
    always @(negedge clk) begin
        if (mem_e) begin
            we_cnt++;
            wr_a    = mem_a;
            wr_size = mem_size;
            wr_di   = mem_di;
        end
    end

    // ---------------- DUT with ACCESS_CYCLES = 3 ----------------
    logic        reset_3, req_valid_3, req_ready_3, rsp_valid_3, rsp_err_3;
    logic [31:0] rsp_rdata_3, mem_di_3;
    logic [7:0]  mem_a_3;
    logic [1:0]  mem_size_3;
    logic        mem_rw_3, mem_e_3;
    state_t      fsm_state_3;
    logic        rsp_ready_3;
    logic [31:0] req_wdata_3;

    mem_access_unit #(.ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset_3),
        .req_valid(req_valid_3), .req_ready(req_ready_3), .req_rw(1'b1),
        .req_size(SZ_WORD), .req_addr(8'h20), .req_wdata(req_wdata_3),
        .req_signed(1'b0),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_rdata(rsp_rdata_3),
        .rsp_err(rsp_err_3),
        .mem_a(mem_a_3), .mem_di(mem_di_3), .mem_do(32'h0), .mem_size(mem_size_3),
        .mem_rw(mem_rw_3), .mem_e(mem_e_3), .fsm_state(fsm_state_3)
    );

    int we_cnt_3 = 0;
    always @(negedge clk) if (mem_e_3) we_cnt_3++;

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];
    int          lat_q[$];

    task automatic collect_rsp(input string tag);
        logic [32:0] e;
        int lat, el;
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        check({tag, "_lat"}, 64'(lat), 64'(el));
        check({tag, "_err"}, 64'(rsp_err), 64'(e[32]));
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(e[31:0]));
    endtask

    task automatic run_req(input string tag, input logic rw, input logic [1:0] size,
                           input logic [7:0] addr, input logic [31:0] wdata, input logic sgn,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int exp_lat, input int exp_we);
        int w0, n;
        exp_q.push_back({exp_err, exp_data});
        lat_q.push_back(exp_lat);
        @(negedge clk);
        w0 = we_cnt;
        req_valid = 1'b1; req_rw = rw; req_size = size;
        req_addr = addr; req_wdata = wdata; req_signed = sgn;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) check({tag, "_accept_timeout"}, 64'(1), 64'(0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        collect_rsp(tag);
        @(posedge clk); #1;
        check({tag, "_taken"}, 64'(fsm_state), 64'(ST_IDLE));
        check({tag, "_we_pulses"}, 64'(we_cnt - w0), 64'(exp_we));
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00;
        req_addr = 8'h00; req_wdata = 32'h0; req_signed = 1'b0; rsp_ready = 1'b1;
        reset_3 = 1'b1; req_valid_3 = 1'b0; rsp_ready_3 = 1'b1; req_wdata_3 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; reset_3 = 1'b0;

        // reset state
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_mem_e", 64'(mem_e), 64'(0));
        check("rst_mem_a", 64'(mem_a), 64'(0));

        // store word, then verify the write strobe and memory bytes
        run_req("st_w10", RW_STORE, SZ_WORD, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2, 1);
        check("st_w10_mem_a", 64'(wr_a), 64'(8'h10));
        check("st_w10_mem_size", 64'(wr_size), 64'(SZ_WORD));
        check("st_w10_mem_di", 64'(wr_di), 64'(32'hDEADBEEF));
        check("st_w10_bytes", 64'({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}),
              64'(32'hDEADBEEF));

        // byte, halfword and word loads
        run_req("ld_b13_s", RW_LOAD, SZ_BYTE, 8'h13, 32'h0, 1'b1, 32'hFFFFFFEF, 1'b0, 2, 0);
        run_req("ld_b13_u", RW_LOAD, SZ_BYTE, 8'h13, 32'h0, 1'b0, 32'h000000EF, 1'b0, 2, 0);
        run_req("ld_h12_s", RW_LOAD, SZ_HALF, 8'h12, 32'h0, 1'b1, 32'hFFFFBEEF, 1'b0, 2, 0);
        run_req("ld_h12_u", RW_LOAD, SZ_HALF, 8'h12, 32'h0, 1'b0, 32'h0000BEEF, 1'b0, 2, 0);
        run_req("ld_w10", RW_LOAD, SZ_WORD, 8'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2, 0);
        run_req("ld_b10_s", RW_LOAD, SZ_BYTE, 8'h10, 32'h0, 1'b1, 32'hFFFFFFDE, 1'b0, 2, 0);

        // error requests: no memory cycle, one-cycle response
        run_req("err_h11", RW_STORE, SZ_HALF, 8'h11, 32'h1234, 1'b0, 32'h0, 1'b1, 1, 0);
        run_req("err_w12", RW_STORE, SZ_WORD, 8'h12, 32'h5678, 1'b0, 32'h0, 1'b1, 1, 0);
        run_req("err_sz3", RW_LOAD, SZ_BAD, 8'h00, 32'h0, 1'b1, 32'h0, 1'b1, 1, 0);
        check("err_mem_untouched", 64'({mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}),
              64'(32'hDEADBEEF));

        // top-of-memory word and halfword stores with read-back
        run_req("st_wfc", RW_STORE, SZ_WORD, 8'hFC, 32'h80FF7F01, 1'b0, 32'h0, 1'b0, 2, 1);
        run_req("ld_wfc", RW_LOAD, SZ_WORD, 8'hFC, 32'h0, 1'b0, 32'h80FF7F01, 1'b0, 2, 0);
        run_req("st_hfe", RW_STORE, SZ_HALF, 8'hFE, 32'hAAAA8001, 1'b0, 32'h0, 1'b0, 2, 1);
        run_req("ld_hfe_s", RW_LOAD, SZ_HALF, 8'hFE, 32'h0, 1'b1, 32'hFFFF8001, 1'b0, 2, 0);
        run_req("ld_bfc_s", RW_LOAD, SZ_BYTE, 8'hFC, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 2, 0);

        // random aligned word store / load-back pairs
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(32, 60)) << 2;
            rd = $urandom;
            run_req("rnd_st", RW_STORE, SZ_WORD, ra, rd, 1'b0, 32'h0, 1'b0, 2, 1);
            run_req("rnd_ld", RW_LOAD, SZ_WORD, ra, 32'h0, 1'b0, rd, 1'b0, 2, 0);
            run_req("rnd_ldb", RW_LOAD, SZ_BYTE, ra + 8'd3, 32'h0, 1'b1,
                    {{24{rd[7]}}, rd[7:0]}, 1'b0, 2, 0);
        end

        // back-pressure on a word load with a second request pending
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        lat_q.push_back(2);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_rw = RW_LOAD; req_size = SZ_WORD; req_addr = 8'h10; req_signed = 1'b0;
        @(posedge clk); #1;
        req_size = SZ_BYTE; req_addr = 8'h13;
        collect_rsp("bp_ld");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEADBEEF));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        exp_q.push_back({1'b0, 32'h000000EF});
        lat_q.push_back(2);
        @(posedge clk); #1;
        check("bp_no_bypass", 64'(fsm_state), 64'(ST_IDLE));
        @(posedge clk); #1;
        check("bp_pending_accept", 64'(fsm_state), 64'(ST_ACCESS));
        req_valid = 1'b0;
        collect_rsp("bp_ld2");
        @(posedge clk); #1;

        // ACCESS_CYCLES = 3: write strobe only in the last access cycle
        w0 = we_cnt_3;
        @(negedge clk);
        req_wdata_3 = 32'h12345678; req_valid_3 = 1'b1;
        @(posedge clk); #1;
        req_valid_3 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("ac3_mem_e", 64'(mem_e_3), 64'(c == 3));
            check("ac3_mem_rw", 64'(mem_rw_3), 64'(1));
            check("ac3_rsp_valid_early", 64'(rsp_valid_3), 64'(0));
        end
        @(posedge clk); #1;
        check("ac3_rsp_valid", 64'(rsp_valid_3), 64'(1));
        check("ac3_rsp_rdata", 64'(rsp_rdata_3), 64'(0));
        check("ac3_rsp_err", 64'(rsp_err_3), 64'(0));
        check("ac3_mem_di", 64'(mem_di_3), 64'(32'h12345678));
        check("ac3_we_pulses", 64'(we_cnt_3 - w0), 64'(1));
        @(posedge clk); #1;
        check("ac3_taken", 64'(fsm_state_3), 64'(ST_IDLE));

        // second store interrupted by reset in its 2nd access cycle
        w0 = we_cnt_3;
        @(negedge clk);
        req_wdata_3 = 32'hCAFEF00D; req_valid_3 = 1'b1;
        @(posedge clk); #1;
        req_valid_3 = 1'b0;
        @(posedge clk); #1;
        check("int_in_access", 64'(mem_rw_3), 64'(1));
        reset_3 = 1'b1;
        #1;
        check("int_mem_rw", 64'(mem_rw_3), 64'(0));
        check("int_mem_e", 64'(mem_e_3), 64'(0));
        check("int_state", 64'(fsm_state_3), 64'(ST_IDLE));
        check("int_mem_a", 64'(mem_a_3), 64'(0));
        check("int_mem_di", 64'(mem_di_3), 64'(0));
        check("int_req_ready", 64'(req_ready_3), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("int_rsp_valid", 64'(rsp_valid_3), 64'(0));
        end
        check("int_we_pulses", 64'(we_cnt_3 - w0), 64'(0));
        check("int_mem_size", 64'(mem_size_3), 64'(0));

        check("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the byte-addressed, big-endian data memory interface: the MEM-stage load/store sequencer of the PPU. Accepts one load/store request per valid/ready handshake and checks alignment. Drives the memory's address, data-in, size, read/write and write-enable lines for a programmable number of cycles. Captures and zero- or sign-extends read data, and returns a response over a second valid/ready handshake.

Parameters:
ACCESS_CYCLES, 1, cycles spent in ACCESS per transfer (≥1); the write enable pulses only in the last one.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; forces IDLE immediately
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_rw  in  1  0 = load, 1 = store
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_addr  in  8  byte address
req_wdata  in  32  store data, right-justified
req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned or illegal-size request
mem_a  out  8  memory address
mem_di  out  32  memory write data
mem_do  in  32  memory read data (combinational, right-justified, upper bits zero)
mem_size  out  2  memory access size
mem_rw  out  1  0 read, 1 write
mem_e  out  1  memory write enable

Behaviour:
- Reset (async): state IDLE, cycle counter 0, latched request 0, rsp_rdata 0, rsp_err 0. Memory-side outputs are decoded from state, so mem_e and mem_rw drop in the same cycle reset asserts. A write interrupted mid-ACCESS is abandoned and no response is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1, rsp_valid=0. On a clock edge with req_valid=1, latch rw/size/addr/wdata/signed and run the check. Error if size=11, if size=01 and addr[0]=1, or if size=10 and addr[1:0]≠00.
  - Error: go to RESP with rsp_err=1 and rsp_rdata=0. No memory cycle; mem_e is never asserted.
  - Otherwise: go to ACCESS with counter=0.
- ACCESS: req_ready=0. mem_a, mem_size, mem_di and mem_rw=rw are driven from the latched request. The counter increments each cycle.
  - mem_e=rw only when counter==ACCESS_CYCLES-1, so a store writes exactly once.
  - On the last cycle's edge: loads capture mem_do with extension into rsp_rdata; stores set rsp_rdata=0. rsp_err=0; go to RESP.
- Extension rules:
  - Byte: signed → {{24{mem_do[7]}}, mem_do[7:0]}; unsigned → {24'b0, mem_do[7:0]}.
  - Halfword: same rule from bit 15.
  - Word: passed through unchanged.
- RESP: rsp_valid=1 and req_ready=0. rsp_rdata and rsp_err hold stable until an edge with rsp_ready=1, then go to IDLE. No response bypass: a new request is not accepted in the same cycle a response is taken.
- Outside ACCESS: mem_rw=0, mem_e=0; mem_a, mem_size and mem_di hold the latched values.
- Latency, request accepted at edge N:
  - Legal request: rsp_valid rises after edge N+ACCESS_CYCLES+1. With the default, 2 cycles; peak throughput is one transfer per ACCESS_CYCLES+2 cycles.
  - Error: rsp_valid rises after edge N+1.
- Address arithmetic: 8-bit; a word at 0xFC touches 0xFC–0xFF, with no wrap beyond that because alignment is enforced.

Decomposition:
- Shared package: size encodings (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10), RW encodings, FSM state enum.
- One natural sub-module, load_extend: combinational size/sign extension of mem_do. The alignment check stays inline.

Test Plan:
1. Store word, addr 0x10, wdata 0xDEADBEEF.
   → mem_e high exactly one cycle with mem_a=0x10, mem_size=10, mem_di=0xDEADBEEF.
   → rsp_valid 2 cycles after accept; rsp_err=0, rsp_rdata=0.
   → Memory bytes 0x10..0x13 = DE AD BE EF.
2. Load byte from 0x13 (holds 0xEF).
   → signed: rsp_rdata=0xFFFFFFEF; unsigned: 0x000000EF. mem_e stays 0 throughout.
3. Load halfword from 0x12 (holds BE EF).
   → signed: 0xFFFFBEEF; unsigned: 0x0000BEEF. Load word from 0x10 → 0xDEADBEEF.
4. Error requests:
   - Halfword at 0x11 → rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept, mem_e never high.
   - Word at 0x12 → same.
   - Size 11 at 0x00 → same.
5. Back-pressure: hold rsp_ready=0 for 5 cycles after a load of 0x10.
   → rsp_valid, rsp_rdata=0xDEADBEEF and req_ready=0 held stable.
   → A pending req_valid is not accepted until the edge after rsp_ready rises.
6. ACCESS_CYCLES=3, store word 0x20, data 0x12345678; assert reset during the 2nd ACCESS cycle of a following store.
   → First store: mem_e pulses only in ACCESS cycle 3; response 4 cycles after accept.
   → Interrupted store: mem_e never pulses, outputs return to reset values immediately, rsp_valid stays 0.
